// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: PC source select and pipeline sequencer states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID. Register 0 is hard-wired, so it never creates a hazard.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRd,
  input  logic [REG_W-1:0] ex_wsel,
  output logic             lu_hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match  = (ex_wsel == id_rs);
  assign rt_match  = id_uses_rt && (ex_wsel == id_rt);
  assign lu_hazard = ex_MemRd && (ex_wsel != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-latch enable/flush and PC select from hazards,
// with saturating stall/flush counters and a D-cache wait watchdog.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 32,
  parameter int WD_LIMIT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRd,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             mem_MemRd,
  input  logic             mem_MemWr,
  input  logic             mem_br_taken,
  input  logic             mem_jump,
  input  logic             mem_halt,
  output logic             pc_en,
  output pc_sel_t          pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wd_err
);

  localparam int              WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIM_V = WD_W'(WD_LIMIT);

  pctrl_state_t    state;
  pctrl_state_t    state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            lu_hazard;
  logic            halt_c;
  logic            dwait_c;
  logic            redirect_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_uses_rt(id_uses_rt),
    .ex_MemRd  (ex_MemRd),
    .ex_wsel   (ex_wsel),
    .lu_hazard (lu_hazard)
  );

  // A data access stalls until dhit; in DWAIT the access is already known pending.
  assign halt_c     = (state == HALTED) || mem_halt;
  assign dwait_c    = !dhit && ((state == DWAIT) || mem_MemRd || mem_MemWr);
  assign redirect_c = !halt_c && !dwait_c && (mem_br_taken || mem_jump);
  assign halt       = (state == HALTED);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-latch controls, highest-priority hazard wins
  always_comb begin
    state_nxt   = state;
    pc_en       = 1'b1;
    pc_sel      = PC_SEQ;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;

    case (state)
      RUN:     if (mem_halt) state_nxt = HALTED;
               else if (dwait_c) state_nxt = DWAIT;
      DWAIT:   if (mem_halt) state_nxt = HALTED;
               else if (dhit) state_nxt = RUN;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase

    if (halt_c || dwait_c) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (redirect_c) begin
      pc_sel      = mem_br_taken ? PC_BR : PC_JMP;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Performance counters: stalls only count while not halted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!halt && !pc_en) stall_cnt <= sat_inc(stall_cnt);
      if (redirect_c)      flush_cnt <= sat_inc(flush_cnt);
    end
  end

  // Watchdog: counts DWAIT cycles, error latches on the WD_LIMIT-th one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else if (state == DWAIT) begin
      if (wd_cnt != WD_LIM_V) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WD_LIM_V - 1'b1) wd_err <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int REG_W    = 5;
  localparam int CNT_W    = 4;
  localparam int WD_LIMIT = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ihit, dhit, id_uses_rt, ex_MemRd;
  logic [REG_W-1:0] id_rs, id_rt, ex_wsel;
  logic             mem_MemRd, mem_MemWr, mem_br_taken, mem_jump, mem_halt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en, halt, wd_err;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  bit m_halted, m_wait, m_wderr;
  int m_wd, m_stall, m_flush;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(
    .REG_W   (REG_W),
    .CNT_W   (CNT_W),
    .WD_LIMIT(WD_LIMIT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_MemRd    (ex_MemRd),
    .ex_wsel     (ex_wsel),
    .mem_MemRd   (mem_MemRd),
    .mem_MemWr   (mem_MemWr),
    .mem_br_taken(mem_br_taken),
    .mem_jump    (mem_jump),
    .mem_halt    (mem_halt),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_en     (idex_en),
    .idex_flush  (idex_flush),
    .exmem_en    (exmem_en),
    .exmem_flush (exmem_flush),
    .memwb_en    (memwb_en),
    .halt        (halt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .wd_err      (wd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_ctl();
    return {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en};
  endfunction

  task automatic idle();
    ihit = 1; dhit = 1; id_uses_rt = 0; ex_MemRd = 0;
    id_rs = 0; id_rt = 0; ex_wsel = 0;
    mem_MemRd = 0; mem_MemWr = 0; mem_br_taken = 0; mem_jump = 0; mem_halt = 0;
  endtask

  task automatic model_reset();
    m_halted = 0; m_wait = 0; m_wderr = 0;
    m_wd = 0; m_stall = 0; m_flush = 0;
  endtask

  // Asserts reset between clock edges and checks its effect before any edge.
  task automatic do_reset();
    idle();
    RST = 1;
    #1;
    model_reset();
    chk("rst_ctl", 32'(dut_ctl()), 32'(10'b1_00_1_0_1_0_1_0_1));
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_wd", 32'(wd_err), 32'd0);
    @(negedge CLK);
    RST = 0;
    @(posedge CLK);
    #1;
  endtask

  // One clock: check against the model mid-cycle, then advance the model.
  task automatic cycle();
    bit hz, wt, br, lu;
    logic [9:0] e;
    @(negedge CLK);
    hz = m_halted || mem_halt;
    wt = !dhit && (m_wait || mem_MemRd || mem_MemWr);
    br = mem_br_taken || mem_jump;
    lu = ex_MemRd && (ex_wsel != 0) &&
         ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
    if (hz || wt)   e = 10'b0_00_0_0_0_0_0_0_0;
    else if (br)    e = {1'b1, (mem_br_taken ? 2'd1 : 2'd2), 7'b1_1_1_1_1_1_1};
    else if (lu)    e = 10'b0_00_0_0_1_1_1_0_1;
    else if (!ihit) e = 10'b0_00_1_1_1_0_1_0_1;
    else            e = 10'b1_00_1_0_1_0_1_0_1;
    chk("ctl", 32'(dut_ctl()), 32'(e));
    chk("halt", 32'(halt), 32'(m_halted));
    chk("stall", 32'(stall_cnt), 32'(m_stall));
    chk("flush", 32'(flush_cnt), 32'(m_flush));
    chk("wd_err", 32'(wd_err), 32'(m_wderr));
    if (!m_halted && !e[9] && m_stall < CMAX) m_stall++;
    if (!hz && !wt && br && m_flush < CMAX) m_flush++;
    if (m_wait) begin
      if (m_wd < WD_LIMIT) m_wd++;
      if (m_wd >= WD_LIMIT) m_wderr = 1;
    end else begin
      m_wd = 0;
    end
    if (!m_halted) begin
      if (mem_halt) begin
        m_halted = 1;
        m_wait = 0;
      end else begin
        m_wait = wt;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_inputs(input int dhit_pct);
    ihit         = ($urandom_range(0, 3) != 0);
    dhit         = ($urandom_range(0, 99) < dhit_pct);
    id_rs        = REG_W'($urandom_range(0, 3));
    id_rt        = REG_W'($urandom_range(0, 3));
    id_uses_rt   = $urandom_range(0, 1) == 1;
    ex_MemRd     = $urandom_range(0, 1) == 1;
    ex_wsel      = REG_W'($urandom_range(0, 3));
    mem_MemRd    = ($urandom_range(0, 3) == 0);
    mem_MemWr    = ($urandom_range(0, 3) == 0);
    mem_br_taken = ($urandom_range(0, 5) == 0);
    mem_jump     = ($urandom_range(0, 7) == 0);
    mem_halt     = ($urandom_range(0, 119) == 0);
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    do_reset();

    // Load-use on rs, then the same with ex_wsel=0
    ex_MemRd = 1; ex_wsel = 8; id_rs = 8;
    cycle();
    ex_wsel = 0;
    cycle();
    idle();

    // D-wait for three cycles, released by dhit
    mem_MemRd = 1; dhit = 0;
    repeat (3) cycle();
    dhit = 1;
    cycle();
    idle();
    cycle();

    // Taken branch together with a load-use hazard
    mem_br_taken = 1; ex_MemRd = 1; ex_wsel = 3; id_rt = 3; id_uses_rt = 1;
    cycle();
    idle();
    cycle();

    // Halt arriving during a data wait
    do_reset();
    mem_MemRd = 1; dhit = 0;
    cycle();
    mem_halt = 1;
    cycle();
    idle();
    ihit = 0;
    repeat (3) cycle();

    // Watchdog: long wait, then dhit
    do_reset();
    mem_MemWr = 1; dhit = 0;
    repeat (7) cycle();
    dhit = 1;
    repeat (2) cycle();
    idle();
    cycle();

    // Randomized epochs; some with a sluggish D-cache to exercise the watchdog
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int n = 0; n < 200; n++) begin
        rand_inputs((ep % 3 == 0) ? 12 : 75);
        cycle();
        if ($urandom_range(0, 149) == 0) do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
